// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: 512-byte sector RAM between a byte-wide CPU port and the SPI-mode SD controller.
// Defining SD_BUF_TIMEOUT_EN adds a watchdog that aborts a stalled transfer after TIMEOUT_CYCLES.
module sd_sector_buffer #(
    parameter logic [26:0] TIMEOUT_CYCLES = 27'd50_000_000
) (
    input  logic        clk_25MHz,
    input  logic        reset_n,
    input  logic        cmd_rd,
    input  logic        cmd_wr,
    input  logic [31:0] sector,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [8:0]  cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        sd_ready,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_address,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic [7:0]  sd_din,
    input  logic        sd_ready_for_next_byte
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_RDY = 3'd1;
    localparam logic [2:0] RD_REQ   = 3'd2;
    localparam logic [2:0] RD_DATA  = 3'd3;
    localparam logic [2:0] WR_REQ   = 3'd4;
    localparam logic [2:0] WR_DATA  = 3'd5;
    localparam logic [2:0] FINISH   = 3'd6;

    logic [2:0] state;
    logic       wr_dir;
    logic [9:0] idx;
    logic       rfnb_prev;
    logic       first_edge_seen;
    logic [7:0] ram [0:511];

    logic       idx_full;
    logic       rfnb_rise;
    logic       byte_take;
    logic       shift_take;
    logic [9:0] idx_next;
    logic       wd_expired;
    logic       unused_sector_msbs;

    // idx saturates at 512, so bit 9 alone marks a full sector
    assign idx_full   = idx[9];
    assign rfnb_rise  = sd_ready_for_next_byte & ~rfnb_prev;
    assign byte_take  = (state == RD_DATA) && sd_byte_available && !idx_full;
    assign shift_take = (state == WR_DATA) && rfnb_rise && first_edge_seen && !idx_full;
    assign idx_next   = idx + {9'd0, byte_take | shift_take};
    assign unused_sector_msbs = ^sector[31:23];

`ifdef SD_BUF_TIMEOUT_EN
    logic [26:0] wd_count;

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            wd_count <= 27'd0;
        end else if (state == IDLE) begin
            wd_count <= 27'd0;
        end else if (state != FINISH && !wd_expired) begin
            wd_count <= wd_count + 27'd1;
        end
    end

    assign wd_expired = (state != IDLE) && (state != FINISH) &&
                        (wd_count == TIMEOUT_CYCLES - 27'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wr_dir          <= 1'b0;
            idx             <= 10'd0;
            rfnb_prev       <= 1'b0;
            first_edge_seen <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            sd_rd           <= 1'b0;
            sd_wr           <= 1'b0;
            sd_address      <= 32'd0;
        end else begin
            done      <= 1'b0;
            rfnb_prev <= sd_ready_for_next_byte;
            if (wd_expired) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
                done  <= 1'b1;
                err   <= 1'b1;
                state <= FINISH;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_rd || cmd_wr) begin
                            wr_dir          <= !cmd_rd;
                            sd_address      <= {sector[22:0], 9'd0};
                            idx             <= 10'd0;
                            first_edge_seen <= 1'b0;
                            busy            <= 1'b1;
                            state           <= WAIT_RDY;
                        end
                    end
                    WAIT_RDY: begin
                        if (sd_ready) state <= wr_dir ? WR_REQ : RD_REQ;
                    end
                    // Strobe is held until the controller leaves ready, then dropped so it cannot retrigger
                    RD_REQ: begin
                        sd_rd <= 1'b1;
                        if (sd_rd && !sd_ready) begin
                            sd_rd <= 1'b0;
                            state <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        idx <= idx_next;
                        if (sd_ready) begin
                            done  <= 1'b1;
                            err   <= (idx_next != 10'd512);
                            state <= FINISH;
                        end
                    end
                    WR_REQ: begin
                        sd_wr <= 1'b1;
                        if (rfnb_rise) first_edge_seen <= 1'b1;
                        if (sd_wr && !sd_ready) begin
                            sd_wr <= 1'b0;
                            state <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        idx <= idx_next;
                        if (rfnb_rise) first_edge_seen <= 1'b1;
                        if (sd_ready) begin
                            done  <= 1'b1;
                            err   <= (idx_next != 10'd512);
                            state <= FINISH;
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (byte_take) begin
            ram[idx[8:0]] <= sd_dout;
        end else if (cpu_we && !busy) begin
            ram[cpu_addr] <= cpu_wdata;
        end
    end

    // sd_din tracks ram[idx] one cycle behind idx, which keeps reloads inside the 2-cycle budget
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            sd_din    <= 8'hFF;
            cpu_rdata <= 8'h00;
        end else begin
            sd_din    <= idx_full ? 8'hFF : ram[idx[8:0]];
            cpu_rdata <= ram[cpu_addr];
        end
    end
endmodule

// File: tb/tb_sd_sector_buffer.sv
// tb_sd_sector_buffer: randomized card/CPU stimulus against a byte-array model of the sector RAM.
// The watchdog scenario runs only when SD_BUF_TIMEOUT_EN is defined.
module tb_sd_sector_buffer;
    logic        clk_25MHz = 1'b0;
    logic        reset_n;
    logic        cmd_rd;
    logic        cmd_wr;
    logic [31:0] sector;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        sd_ready;
    logic        sd_rd;
    logic        sd_wr;
    logic [31:0] sd_address;
    logic [7:0]  sd_dout;
    logic        sd_byte_available;
    logic [7:0]  sd_din;
    logic        sd_ready_for_next_byte;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    logic [7:0] ref_ram [0:511];

    sd_sector_buffer #(.TIMEOUT_CYCLES(27'd1000)) dut (
        .clk_25MHz(clk_25MHz),
        .reset_n(reset_n),
        .cmd_rd(cmd_rd),
        .cmd_wr(cmd_wr),
        .sector(sector),
        .busy(busy),
        .done(done),
        .err(err),
        .cpu_addr(cpu_addr),
        .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .sd_ready(sd_ready),
        .sd_rd(sd_rd),
        .sd_wr(sd_wr),
        .sd_address(sd_address),
        .sd_dout(sd_dout),
        .sd_byte_available(sd_byte_available),
        .sd_din(sd_din),
        .sd_ready_for_next_byte(sd_ready_for_next_byte)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    always @(negedge clk_25MHz) begin
        if (done === 1'b1) done_count++;
    end

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cpuWrite(input int addr, input logic [7:0] data);
        cpu_addr  = addr[8:0];
        cpu_wdata = data;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
        ref_ram[addr] = data;
    endtask

    task automatic cpuRead(input int addr, output logic [7:0] data);
        cpu_addr = addr[8:0];
        tick();
        data = cpu_rdata;
    endtask

    task automatic verifyRam(input string tag);
        int bad;
        logic [7:0] d;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            cpuRead(i, d);
            if (d !== ref_ram[i]) bad++;
        end
        checkOutput(tag, bad, 0);
    endtask

    // Card side of a read: streams nbytes pulses, optionally resetting the DUT after abort_after bytes
    task automatic runRead(input logic [31:0] sec, input int nbytes, input int mode,
                           input int abort_after, input bit both);
        int n;
        int start_done;
        logic [7:0] b;
        start_done = done_count;
        sector = sec;
        cmd_rd = 1'b1;
        cmd_wr = both;
        tick();
        cmd_rd = 1'b0;
        cmd_wr = 1'b0;
        checkOutput("rd_busy_on_accept", busy, 1);
        n = 0;
        while (sd_rd !== 1'b1 && n < 20) begin tick(); n++; end
        checkOutput("rd_strobe_latency", n, 2);
        checkOutput("rd_no_wr_strobe", sd_wr, 0);
        checkOutput("rd_address", sd_address, {sec[22:0], 9'd0});
        sd_ready = 1'b0;
        n = 0;
        while (sd_rd !== 1'b0 && n < 20) begin tick(); n++; end
        checkOutput("rd_strobe_release", sd_rd, 0);
        tick();
        for (int k = 0; k < nbytes; k++) begin
            if (k == abort_after) begin
                reset_n = 1'b0;
                #1;
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_sd_rd", sd_rd, 0);
                checkOutput("rst_sd_din", sd_din, 8'hFF);
                checkOutput("rst_sd_address", sd_address, 0);
                checkOutput("rst_done", done, 0);
                tick();
                tick();
                reset_n  = 1'b1;
                sd_ready = 1'b1;
                tick();
                return;
            end
            repeat ($urandom_range(0, 2)) tick();
            b = (mode == 0) ? k[7:0] : 8'($urandom);
            sd_dout = b;
            sd_byte_available = 1'b1;
            if (k == 5) begin
                cpu_addr  = 9'd450;
                cpu_wdata = ~ref_ram[450];
                cpu_we    = 1'b1;
            end
            if (k == 20) cmd_wr = 1'b1;
            tick();
            sd_byte_available = 1'b0;
            cpu_we = 1'b0;
            cmd_wr = 1'b0;
            tick();
            if (k < 512) ref_ram[k] = b;
        end
        sd_ready = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 10) begin tick(); n++; end
        checkOutput("rd_done_latency_ok", (n >= 1 && n <= 2), 1);
        checkOutput("rd_err", err, (nbytes >= 512) ? 0 : 1);
        checkOutput("rd_busy_with_done", busy, 1);
        tick();
        checkOutput("rd_done_falls", done, 0);
        checkOutput("rd_busy_falls", busy, 0);
        repeat (3) tick();
        checkOutput("rd_done_count", done_count - start_done, 1);
    endtask

    // Card side of a write: one ignored command-phase edge, then one edge per byte taken
    task automatic runWrite(input logic [31:0] sec, input int nbytes);
        int n;
        int bad;
        int start_done;
        start_done = done_count;
        sector = sec;
        cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
        n = 0;
        while (sd_wr !== 1'b1 && n < 20) begin tick(); n++; end
        checkOutput("wr_strobe_latency", n, 2);
        checkOutput("wr_no_rd_strobe", sd_rd, 0);
        checkOutput("wr_address", sd_address, {sec[22:0], 9'd0});
        sd_ready = 1'b0;
        n = 0;
        while (sd_wr !== 1'b0 && n < 20) begin tick(); n++; end
        checkOutput("wr_strobe_release", sd_wr, 0);
        tick();
        tick();
        sd_ready_for_next_byte = 1'b1;
        tick();
        sd_ready_for_next_byte = 1'b0;
        bad = 0;
        for (int k = 0; k < nbytes; k++) begin
            repeat (3 + $urandom_range(0, 2)) tick();
            if (k == 0) checkOutput("wr_first_byte", sd_din, ref_ram[0]);
            if (sd_din !== ref_ram[k]) bad++;
            sd_ready_for_next_byte = 1'b1;
            tick();
            sd_ready_for_next_byte = 1'b0;
        end
        checkOutput("wr_data_bytes", bad, 0);
        repeat (3) tick();
        sd_ready = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 10) begin tick(); n++; end
        checkOutput("wr_done_latency_ok", (n >= 1 && n <= 2), 1);
        checkOutput("wr_err", err, (nbytes == 512) ? 0 : 1);
        tick();
        checkOutput("wr_busy_falls", busy, 0);
        repeat (3) tick();
        checkOutput("wr_done_count", done_count - start_done, 1);
    endtask

    initial begin
        logic [7:0] d;
        reset_n = 1'b0;
        cmd_rd = 1'b0;
        cmd_wr = 1'b0;
        sector = 32'd0;
        cpu_addr = 9'd0;
        cpu_we = 1'b0;
        cpu_wdata = 8'd0;
        sd_ready = 1'b1;
        sd_dout = 8'd0;
        sd_byte_available = 1'b0;
        sd_ready_for_next_byte = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_sd_rd", sd_rd, 0);
        checkOutput("reset_sd_wr", sd_wr, 0);
        checkOutput("reset_sd_address", sd_address, 0);
        checkOutput("reset_sd_din", sd_din, 8'hFF);
        checkOutput("reset_cpu_rdata", cpu_rdata, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 512; i++) cpuWrite(i, 8'($urandom));
        verifyRam("ram_after_fill");

        runRead(32'd3, 512, 0, -1, 1'b0);
        cpuRead(9'h1FF, d);
        checkOutput("rd_last_byte", d, 8'hFF);
        verifyRam("ram_after_ramp_read");

        for (int i = 0; i < 512; i++) cpuWrite(i, 8'(i) ^ 8'hA5);
        runWrite(32'd1, 512);

        runRead(32'h0012_3457, 512, 1, -1, 1'b1);
        verifyRam("ram_after_both_cmds");

        runRead(32'd9, 300, 1, -1, 1'b0);
        verifyRam("ram_after_short_read");

        runRead(32'd10, 520, 1, -1, 1'b0);
        verifyRam("ram_after_long_read");

        runRead(32'd11, 512, 1, 100, 1'b0);
        runRead(32'd12, 512, 1, -1, 1'b0);
        verifyRam("ram_after_reset_recovery");

        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 16; j++) cpuWrite($urandom_range(0, 511), 8'($urandom));
            runWrite($urandom, 512);
        end

        runWrite(32'd5, 400);

`ifdef SD_BUF_TIMEOUT_EN
        begin
            int n;
            sd_ready = 1'b0;
            sector = 32'd4;
            cmd_rd = 1'b1;
            tick();
            cmd_rd = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 1100) begin tick(); n++; end
            checkOutput("wd_latency_ok", (n >= 998 && n <= 1002), 1);
            checkOutput("wd_err", err, 1);
            checkOutput("wd_sd_rd", sd_rd, 0);
            tick();
            checkOutput("wd_busy_falls", busy, 0);
            sd_ready = 1'b1;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sd_sector_buffer.md
# sd_sector_buffer

Sector-level front end that sits directly upstream of the SPI-mode SD card controller. It owns a 512-byte sector RAM that the CPU reads and writes byte-wise. On a CPU command it drives the controller's rd/wr/address handshake to stream one full sector between the card and the RAM, then reports completion with a done/err pulse.

## Interface
- `TIMEOUT_CYCLES`, default 27'd50_000_000: watchdog limit in clock cycles (used only with `SD_BUF_TIMEOUT_EN`).
- `clk_25MHz`  in  1  system clock; same 25 MHz clock as the SD controller.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_rd`  in  1  when high in IDLE, loads `sector` into the RAM from the card.
- `cmd_wr`  in  1  when high in IDLE, writes the RAM to `sector` on the card.
- `sector`  in  32  sector number, sampled when a command is accepted.
- `busy`  out  1  high from command accept until the cycle after done.
- `done`  out  1  one-cycle pulse when a transfer ends.
- `err`  out  1  valid with `done`; 1 = short read or timeout.
- `cpu_addr`  in  9  RAM byte index.
- `cpu_we`  in  1  RAM write strobe; ignored while `busy`.
- `cpu_wdata`  in  8  RAM write data.
- `cpu_rdata`  out  8  `ram[cpu_addr]`, registered, 1-cycle latency; valid at all times.
- `sd_ready`  in  1  SD controller `ready`.
- `sd_rd` / `sd_wr`  out  1  to SD controller `rd` / `wr`.
- `sd_address`  out  32  to SD controller `address`; equals {sector[22:0], 9'b0}.
- `sd_dout`  in  8  SD controller `dout`.
- `sd_byte_available`  in  1  SD controller `byte_available`, one-cycle pulse per byte.
- `sd_din`  out  8  to SD controller `din`.
- `sd_ready_for_next_byte`  in  1  SD controller `ready_for_next_byte`.

## Operation
- States: IDLE, WAIT_RDY, RD_REQ, RD_DATA, WR_REQ, WR_DATA, FINISH.
- IDLE:
  - `cmd_rd` has priority over `cmd_wr`.
  - On accept: latch `sector`, clear byte index `idx`, set `busy`, go to WAIT_RDY.
- WAIT_RDY: wait for `sd_ready` = 1, then go to RD_REQ or WR_REQ.
- RD_REQ / WR_REQ:
  - Assert `sd_rd` / `sd_wr`. Hold it until `sd_ready` = 0, then deassert.
  - Go to RD_DATA / WR_DATA. The strobe must be low before the controller can return to ready.
- RD_DATA:
  - Each `sd_byte_available` pulse with `idx` < 512: write `ram[idx]` ← `sd_dout`, then `idx`+1.
  - Pulses with `idx` = 512 are dropped; `idx` saturates at 512.
  - On `sd_ready` = 1: go to FINISH with err = (`idx` != 512).
- WR_DATA:
  - `sd_din` is a register that always holds `ram[idx]`.
  - Track rising edges of `sd_ready_for_next_byte`. The first edge, from the command phase, is ignored.
  - Each later edge means byte `idx` was taken: `idx`+1 and reload `sd_din` within 2 cycles. The byte-shift window is 16 cycles.
  - On `sd_ready` = 1: go to FINISH with err = (`idx` != 512).
- FINISH: pulse `done` with `err`, return to IDLE. `busy` drops the same cycle.
- CPU port:
  - Writes take effect only when not `busy`.
  - Reads are always serviced, but data read mid-transfer is undefined.
- Commands asserted while `busy` are ignored, not queued.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `sd_rd`=0, `sd_wr`=0, `sd_address`=0, `sd_din`=8'hFF, `cpu_rdata`=0, state=IDLE, `idx`=0.
- RAM contents are not cleared by reset.
- Command accept to `sd_rd`/`sd_wr` high: 2 cycles if `sd_ready` is already high.
- Last data byte / `sd_ready` rise to `done`: 1–2 cycles.
- Reset mid-transfer: all outputs return to reset values immediately and strobes drop. The SD controller is not aborted and finishes its sector on its own.
- `done` and `busy` fall together. A new command is accepted on the cycle after `done`.

## Configuration
- Macro: `SD_BUF_TIMEOUT_EN`.
- Defined:
  - A 27-bit watchdog counts cycles in every non-IDLE state.
  - On reaching `TIMEOUT_CYCLES`: drop `sd_rd`/`sd_wr`, pulse `done` with err=1, return to IDLE.
  - The counter clears on each command accept.
- Undefined: no watchdog; a stalled card holds `busy` indefinitely.

## Test plan
- Read, card model returns bytes 0x00..0xFF twice (512 pulses) at sector 3 → `sd_address`=0x600, `done`=1, err=0; `cpu_rdata` at address 0x1FF = 0xFF.
- CPU fills ram[i]=i^0xA5, then `cmd_wr` sector 1 → model captures 512 bytes equal to i^0xA5 in order, `sd_address`=0x200, `done` with err=0.
- `cmd_rd` and `cmd_wr` asserted together → read performed; `cmd_wr` pulsed while `busy` → ignored, exactly one `done`.
- Model returns ready after only 300 bytes → `done` with err=1; a model sending 520 pulses → ram[0..511] correct, err=0.
- `reset_n` low mid-read after 100 bytes → `busy`/`sd_rd` 0 at once, `sd_din`=0xFF; after release a new read completes with err=0.
- With `SD_BUF_TIMEOUT_EN` and `TIMEOUT_CYCLES`=1000, `sd_ready` held low → `done` with err=1 at 1000±2 cycles after accept.
